msx_block_table_loader: RTL and testbench
=========================================

# msx_block_table_loader

Streaming parser for the machine-configuration image that the HPS downloads at boot or on cartridge change. It sits between the ioctl download path and the slot/subslot/page block table plus the RAM lookup table. It decodes a byte stream into `MSX::lookup_RAM_t` entries and `MSX::block_t` entries and writes each one as a single-cycle strobe. It validates every field against the `mapper_typ_t` and `device_typ_t` encodings and reports the first error found.

## Interface
Parameters:
- `MAX_RAM`, 16: maximum RAM lookup entries; index width is 4.
- `MAX_BLK`, 64: maximum block entries (4 slots × 4 subslots × 4 pages); index width is 6.
- `MAGIC`, 8'h4D: required first byte of the stream.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `dl_active`  in  1  high while a download is in progress. A rising edge starts a parse; a falling edge ends the stream.
- `dl_wr`  in  1  byte strobe, one byte per asserted cycle, no backpressure.
- `dl_data`  in  8  stream byte.
- `ram_we`  out  1  one-cycle write strobe for a RAM lookup entry.
- `ram_idx`  out  4  entry index.
- `ram_addr`  out  27  `lookup_RAM_t.addr`.
- `ram_size`  out  16  `lookup_RAM_t.size`.
- `ram_ro`  out  1  `lookup_RAM_t.ro`.
- `blk_we`  out  1  one-cycle write strobe for a block entry.
- `blk_idx`  out  6  block index, formed as {slot, subslot, page}.
- `blk_ref_ram`  out  4  `block_t.ref_ram`.
- `blk_ref_sram`  out  2  `block_t.ref_sram`.
- `blk_offset_ram`  out  2  `block_t.offset_ram`.
- `blk_mapper`  out  5  `block_t.mapper`.
- `blk_device`  out  4  `block_t.device`.
- `blk_cart_num`  out  1  `block_t.cart_num`.
- `blk_external`  out  1  `block_t.external`.
- `busy`  out  1  a parse is in progress.
- `done`  out  1  image complete and valid; sticky.
- `error`  out  1  parse failed; sticky.
- `err_code`  out  3  1 bad magic, 2 count range, 3 bad field, 4 dangling ref_ram, 5 truncated.

## Operation
Stream format:
- Header: MAGIC, NRAM, NBLK.
- Then NRAM RAM records of 8 bytes each:
  - bytes 0–3: addr, little-endian; byte 3 bits [7:3] must be 0.
  - bytes 4–5: size, little-endian.
  - byte 6: bit 0 is ro; bits [7:1] must be 0.
  - byte 7: reserved, ignored.
  - ram_idx is the record ordinal.
- Then NBLK block records of 4 bytes each:
  - byte 0: index[5:0]; bits [7:6] must be 0.
  - byte 1: ref_ram[3:0], ref_sram[5:4], offset_ram[7:6].
  - byte 2: mapper[4:0], cart_num[5], external[6]; bit 7 must be 0.
  - byte 3: device[3:0]; bits [7:4] must be 0.

State machine:
- States: IDLE, MAGIC, NRAM, NBLK, RAM_REC, BLK_REC, DONE, ERROR.
- IDLE/DONE/ERROR → MAGIC on a `dl_active` rising edge. This clears done, error and err_code and sets busy.
- MAGIC: a byte ≠ MAGIC → ERROR with code 1.
- NRAM: a value > MAX_RAM → ERROR with code 2.
- NBLK: a value > MAX_BLK → ERROR with code 2.
- After the header, go to RAM_REC if NRAM > 0, else BLK_REC if NBLK > 0, else DONE.
- A 3-bit byte counter tracks position within the current record. An entry counter counts records of the current type and is compared against NRAM or NBLK.

Field checks:
- Each byte is checked as it arrives. The first violation goes to ERROR with code 3 and the record is not written.
- mapper > 18 (MAPPER_HALNOTE) is a code 3 violation.
- device > 4 (DEVICE_MFRSD0) is a code 3 violation.
- ref_ram ≥ NRAM while mapper ≠ MAPPER_UNUSED → code 4. This is checked when byte 2 arrives.

End of stream:
- `dl_active` falling while in MAGIC..BLK_REC → ERROR with code 5.
- In DONE, further `dl_wr` bytes are ignored.
- `dl_wr` with `dl_active` low is ignored.

Error behaviour:
- Only the first error is latched.
- Entries already written are not retracted. The consumer must qualify the tables with `done`.

## Timing
- Reset: every output is 0 and the state is IDLE.
- A `dl_wr` in the same cycle as the `dl_active` rise is accepted as the MAGIC byte.
- A `dl_wr` in the same cycle as the `dl_active` fall is processed first; truncation is then evaluated against the updated state.
- `ram_we` and `blk_we` pulse high for exactly one cycle, in the cycle after the record's last byte is accepted. Data outputs are valid in that cycle and hold until the next write.
- Back-to-back records produce strobes on consecutive record boundaries. The minimum spacing is 4 cycles for block records and 8 cycles for RAM records.
- `done` rises in the cycle after the final required byte. `busy` falls in that same cycle.
- `error` rises in the cycle after the offending byte or the falling edge.
- `reset_n` asserted mid-parse clears immediately and asynchronously. No strobe is emitted.

## Test plan
- **Valid image:** stream 4D 01 01, then RAM record 00 00 01 00 00 40 01 xx, then block 05 00 04 01.
  - ram_we at idx 0 with addr 0x10000, size 0x4000, ro 1.
  - blk_we at idx 5 with mapper 4 (ASCII8), device 1.
  - done=1 after the last byte; no extra strobes.
- **Empty header:** 4D 00 00 → done one cycle later; no strobes. A following byte 0xFF is ignored.
- **Bad magic:** first byte 0x4E → error=1, err_code=1, no strobes. A new `dl_active` rise clears error.
- **Range and field errors:**
  - NRAM = 17 → code 2.
  - Block byte 2 = 0x13 (mapper 19) → code 3, no blk_we.
  - ref_ram 2 with NRAM = 1 and mapper 2 → code 4.
- **Truncation:** drop `dl_active` after the 5th byte of a RAM record → code 5, no ram_we.
- **Reset mid-record:** assert reset_n=0 during BLK_REC → all outputs 0. A following clean download completes normally.

Source files
------------

// File: rtl/msx_block_table_loader.sv
// Streaming parser for the MSX machine-configuration image: decodes the ioctl byte
// stream into RAM lookup and slot/subslot/page block table write strobes.
module msx_block_table_loader #(
    parameter int         MAX_RAM = 16,
    parameter int         MAX_BLK = 64,
    parameter logic [7:0] MAGIC   = 8'h4D
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_data,
    output logic        ram_we,
    output logic [3:0]  ram_idx,
    output logic [26:0] ram_addr,
    output logic [15:0] ram_size,
    output logic        ram_ro,
    output logic        blk_we,
    output logic [5:0]  blk_idx,
    output logic [3:0]  blk_ref_ram,
    output logic [1:0]  blk_ref_sram,
    output logic [1:0]  blk_offset_ram,
    output logic [4:0]  blk_mapper,
    output logic [3:0]  blk_device,
    output logic        blk_cart_num,
    output logic        blk_external,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_MAGIC, S_NRAM, S_NBLK, S_RAM_REC, S_BLK_REC, S_DONE, S_ERROR
    } state_t;

    localparam logic [2:0] ERR_MAGIC    = 3'd1;
    localparam logic [2:0] ERR_RANGE    = 3'd2;
    localparam logic [2:0] ERR_FIELD    = 3'd3;
    localparam logic [2:0] ERR_DANGLING = 3'd4;
    localparam logic [2:0] ERR_TRUNC    = 3'd5;

    localparam logic [7:0] MAX_RAM_B     = 8'(MAX_RAM);
    localparam logic [7:0] MAX_BLK_B     = 8'(MAX_BLK);
    localparam logic [4:0] MAPPER_UNUSED = 5'd0;
    localparam logic [4:0] MAPPER_MAX    = 5'd18;
    localparam logic [3:0] DEVICE_MAX    = 4'd4;

    state_t      state;
    state_t      eff_state;
    logic        dl_active_q;
    logic [2:0]  byte_cnt;
    logic [6:0]  ent_cnt;
    logic [6:0]  ent_nxt;
    logic [6:0]  nram;
    logic [6:0]  nblk;

    // Record fields staged until the record's last byte arrives
    logic [26:0] st_addr;
    logic [15:0] st_size;
    logic        st_ro;
    logic [5:0]  st_idx;
    logic [3:0]  st_ref_ram;
    logic [1:0]  st_ref_sram;
    logic [1:0]  st_offset_ram;
    logic [4:0]  st_mapper;
    logic        st_cart_num;
    logic        st_external;

    logic        dl_rise;
    logic        dl_fall;
    logic        start;
    logic        accept;
    logic        parsing;
    logic        last_byte;
    logic [2:0]  byte_code;

    // Validity of one incoming byte in its stream position; 0 means acceptable.
    function automatic logic [2:0] byte_check(
        input state_t     st,
        input logic [2:0] pos,
        input logic [7:0] b,
        input logic [3:0] ref_ram,
        input logic [6:0] n_ram
    );
        byte_check = 3'd0;
        case (st)
            S_MAGIC: if (b != MAGIC)     byte_check = ERR_MAGIC;
            S_NRAM:  if (b > MAX_RAM_B)  byte_check = ERR_RANGE;
            S_NBLK:  if (b > MAX_BLK_B)  byte_check = ERR_RANGE;
            S_RAM_REC: begin
                if (pos == 3'd3 && b[7:3] != 5'd0) byte_check = ERR_FIELD;
                if (pos == 3'd6 && b[7:1] != 7'd0) byte_check = ERR_FIELD;
            end
            S_BLK_REC: begin
                case (pos)
                    3'd0: if (b[7:6] != 2'd0) byte_check = ERR_FIELD;
                    3'd2: begin
                        if (b[7] || b[4:0] > MAPPER_MAX)
                            byte_check = ERR_FIELD;
                        else if (b[4:0] != MAPPER_UNUSED && {3'd0, ref_ram} >= n_ram)
                            byte_check = ERR_DANGLING;
                    end
                    3'd3: if (b[7:4] != 4'd0 || b[3:0] > DEVICE_MAX) byte_check = ERR_FIELD;
                    default: byte_check = 3'd0;
                endcase
            end
            default: byte_check = 3'd0;
        endcase
    endfunction

    // A byte coinciding with the dl_active fall is still taken; a byte with the
    // rise is decoded as MAGIC by presenting the post-start state to the decoder.
    always_comb begin
        dl_rise   = dl_active && !dl_active_q;
        dl_fall   = !dl_active && dl_active_q;
        start     = dl_rise && (state == S_IDLE || state == S_DONE || state == S_ERROR);
        eff_state = start ? S_MAGIC : state;
        accept    = dl_wr && (dl_active || dl_active_q);
        parsing   = (eff_state == S_MAGIC) || (eff_state == S_NRAM) || (eff_state == S_NBLK) ||
                    (eff_state == S_RAM_REC) || (eff_state == S_BLK_REC);
        ent_nxt   = ent_cnt + 7'd1;
        byte_code = byte_check(eff_state, byte_cnt, dl_data, st_ref_ram, nram);
        last_byte = 1'b0;
        case (eff_state)
            S_NBLK:    last_byte = (nram == 7'd0) && (dl_data == 8'd0);
            S_RAM_REC: last_byte = (byte_cnt == 3'd7) && (ent_nxt == nram) && (nblk == 7'd0);
            S_BLK_REC: last_byte = (byte_cnt == 3'd3) && (ent_nxt == nblk);
            default:   last_byte = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            dl_active_q    <= 1'b0;
            byte_cnt       <= 3'd0;
            ent_cnt        <= 7'd0;
            nram           <= 7'd0;
            nblk           <= 7'd0;
            st_addr        <= 27'd0;
            st_size        <= 16'd0;
            st_ro          <= 1'b0;
            st_idx         <= 6'd0;
            st_ref_ram     <= 4'd0;
            st_ref_sram    <= 2'd0;
            st_offset_ram  <= 2'd0;
            st_mapper      <= 5'd0;
            st_cart_num    <= 1'b0;
            st_external    <= 1'b0;
            ram_we         <= 1'b0;
            ram_idx        <= 4'd0;
            ram_addr       <= 27'd0;
            ram_size       <= 16'd0;
            ram_ro         <= 1'b0;
            blk_we         <= 1'b0;
            blk_idx        <= 6'd0;
            blk_ref_ram    <= 4'd0;
            blk_ref_sram   <= 2'd0;
            blk_offset_ram <= 2'd0;
            blk_mapper     <= 5'd0;
            blk_device     <= 4'd0;
            blk_cart_num   <= 1'b0;
            blk_external   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_code       <= 3'd0;
        end else begin
            dl_active_q <= dl_active;
            ram_we      <= 1'b0;
            blk_we      <= 1'b0;

            if (start) begin
                state    <= S_MAGIC;
                busy     <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
                err_code <= 3'd0;
            end

            if (accept && parsing) begin
                if (byte_code != 3'd0) begin
                    state    <= S_ERROR;
                    error    <= 1'b1;
                    err_code <= byte_code;
                    busy     <= 1'b0;
                end else begin
                    case (eff_state)
                        S_MAGIC: state <= S_NRAM;
                        S_NRAM: begin
                            nram  <= dl_data[6:0];
                            state <= S_NBLK;
                        end
                        S_NBLK: begin
                            nblk     <= dl_data[6:0];
                            byte_cnt <= 3'd0;
                            ent_cnt  <= 7'd0;
                            if (nram != 7'd0)
                                state <= S_RAM_REC;
                            else if (dl_data != 8'd0)
                                state <= S_BLK_REC;
                            else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                        S_RAM_REC: begin
                            byte_cnt <= byte_cnt + 3'd1;
                            case (byte_cnt)
                                3'd0: st_addr[7:0]   <= dl_data;
                                3'd1: st_addr[15:8]  <= dl_data;
                                3'd2: st_addr[23:16] <= dl_data;
                                3'd3: st_addr[26:24] <= dl_data[2:0];
                                3'd4: st_size[7:0]   <= dl_data;
                                3'd5: st_size[15:8]  <= dl_data;
                                3'd6: st_ro          <= dl_data[0];
                                default: begin
                                    ram_we   <= 1'b1;
                                    ram_idx  <= ent_cnt[3:0];
                                    ram_addr <= st_addr;
                                    ram_size <= st_size;
                                    ram_ro   <= st_ro;
                                    if (ent_nxt == nram) begin
                                        ent_cnt <= 7'd0;
                                        if (nblk != 7'd0)
                                            state <= S_BLK_REC;
                                        else begin
                                            state <= S_DONE;
                                            done  <= 1'b1;
                                            busy  <= 1'b0;
                                        end
                                    end else begin
                                        ent_cnt <= ent_nxt;
                                    end
                                end
                            endcase
                        end
                        S_BLK_REC: begin
                            byte_cnt <= (byte_cnt == 3'd3) ? 3'd0 : byte_cnt + 3'd1;
                            case (byte_cnt)
                                3'd0: st_idx <= dl_data[5:0];
                                3'd1: begin
                                    st_ref_ram    <= dl_data[3:0];
                                    st_ref_sram   <= dl_data[5:4];
                                    st_offset_ram <= dl_data[7:6];
                                end
                                3'd2: begin
                                    st_mapper   <= dl_data[4:0];
                                    st_cart_num <= dl_data[5];
                                    st_external <= dl_data[6];
                                end
                                default: begin
                                    blk_we         <= 1'b1;
                                    blk_idx        <= st_idx;
                                    blk_ref_ram    <= st_ref_ram;
                                    blk_ref_sram   <= st_ref_sram;
                                    blk_offset_ram <= st_offset_ram;
                                    blk_mapper     <= st_mapper;
                                    blk_cart_num   <= st_cart_num;
                                    blk_external   <= st_external;
                                    blk_device     <= dl_data[3:0];
                                    if (ent_nxt == nblk) begin
                                        ent_cnt <= 7'd0;
                                        state   <= S_DONE;
                                        done    <= 1'b1;
                                        busy    <= 1'b0;
                                    end else begin
                                        ent_cnt <= ent_nxt;
                                    end
                                end
                            endcase
                        end
                        default: state <= state;
                    endcase
                end
            end

            // Stream ended early, judged after any byte taken in this same cycle
            if (dl_fall && parsing && !(accept && (byte_code != 3'd0 || last_byte))) begin
                state    <= S_ERROR;
                error    <= 1'b1;
                err_code <= ERR_TRUNC;
                busy     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msx_block_table_loader.sv
// Directed bench for msx_block_table_loader: valid images, header/field errors,
// truncation, end-of-stream timing and mid-parse reset.
module tb_msx_block_table_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [7:0]  dl_data = 8'd0;
    logic        ram_we;
    logic [3:0]  ram_idx;
    logic [26:0] ram_addr;
    logic [15:0] ram_size;
    logic        ram_ro;
    logic        blk_we;
    logic [5:0]  blk_idx;
    logic [3:0]  blk_ref_ram;
    logic [1:0]  blk_ref_sram;
    logic [1:0]  blk_offset_ram;
    logic [4:0]  blk_mapper;
    logic [3:0]  blk_device;
    logic        blk_cart_num;
    logic        blk_external;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  err_code;

    int checks = 0;
    int failures = 0;
    int ram_strobes = 0;
    int blk_strobes = 0;

    msx_block_table_loader dut (
        .clk(clk), .reset_n(reset_n), .dl_active(dl_active), .dl_wr(dl_wr), .dl_data(dl_data),
        .ram_we(ram_we), .ram_idx(ram_idx), .ram_addr(ram_addr), .ram_size(ram_size), .ram_ro(ram_ro),
        .blk_we(blk_we), .blk_idx(blk_idx), .blk_ref_ram(blk_ref_ram), .blk_ref_sram(blk_ref_sram),
        .blk_offset_ram(blk_offset_ram), .blk_mapper(blk_mapper), .blk_device(blk_device),
        .blk_cart_num(blk_cart_num), .blk_external(blk_external),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we === 1'b1) ram_strobes++;
        if (blk_we === 1'b1) blk_strobes++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        dl_wr = 1'b1;
        dl_data = b;
        @(posedge clk); #1;
        dl_wr = 1'b0;
        dl_data = 8'd0;
    endtask

    task automatic begin_dl();
        dl_active = 1'b1;
    endtask

    task automatic end_dl();
        dl_active = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [80:0] all_out;
        reset_n = 1'b0;
        idle_cycles(2);
        all_out = {ram_we, ram_idx, ram_addr, ram_size, ram_ro, blk_we, blk_idx, blk_ref_ram,
                   blk_ref_sram, blk_offset_ram, blk_mapper, blk_device, blk_cart_num,
                   blk_external, busy, done, error, err_code};
        checks++;
        if (all_out !== 81'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        reset_n = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_valid_image();
        logic [7:0] img [15];
        int r0, b0;
        img = '{8'h4D, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h01, 8'hAA,
                8'h05, 8'h00, 8'h04, 8'h01};
        r0 = ram_strobes; b0 = blk_strobes;
        begin_dl();
        send_byte(img[0]);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL valid_busy: got %b expected 1", busy); end
        for (int i = 1; i < 11; i++) send_byte(img[i]);
        checks++;
        if (ram_we !== 1'b1) begin failures++; $display("FAIL valid_ram_we_pulse: got %b expected 1", ram_we); end
        checks++;
        if ({ram_idx, ram_addr, ram_size, ram_ro} !== {4'd0, 27'h0010000, 16'h4000, 1'b1}) begin
            failures++;
            $display("FAIL valid_ram_fields: got idx=%0d addr=%h size=%h ro=%b expected idx=0 addr=0010000 size=4000 ro=1",
                     ram_idx, ram_addr, ram_size, ram_ro);
        end
        send_byte(img[11]);
        checks++;
        if (ram_we !== 1'b0) begin failures++; $display("FAIL valid_ram_we_width: got %b expected 0", ram_we); end
        for (int i = 12; i < 15; i++) send_byte(img[i]);
        checks++;
        if ({blk_we, blk_idx, blk_mapper, blk_device, blk_ref_ram} !== {1'b1, 6'd5, 5'd4, 4'd1, 4'd0}) begin
            failures++;
            $display("FAIL valid_blk_fields: got we=%b idx=%0d mapper=%0d dev=%0d ref=%0d expected we=1 idx=5 mapper=4 dev=1 ref=0",
                     blk_we, blk_idx, blk_mapper, blk_device, blk_ref_ram);
        end
        checks++;
        if ({done, busy, error} !== 3'b100) begin
            failures++;
            $display("FAIL valid_done: got done/busy/error=%b%b%b expected 100", done, busy, error);
        end
        end_dl();
        idle_cycles(3);
        checks++;
        if ((ram_strobes - r0) != 1 || (blk_strobes - b0) != 1) begin
            failures++;
            $display("FAIL valid_strobe_count: got ram=%0d blk=%0d expected 1 1", ram_strobes - r0, blk_strobes - b0);
        end
    endtask

    task automatic test_empty_header();
        int r0, b0;
        r0 = ram_strobes; b0 = blk_strobes;
        begin_dl();
        send_byte(8'h4D); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if ({done, busy, error} !== 3'b100) begin
            failures++;
            $display("FAIL empty_done: got done/busy/error=%b%b%b expected 100", done, busy, error);
        end
        send_byte(8'hFF);
        end_dl();
        idle_cycles(2);
        checks++;
        if ({done, error, err_code} !== 5'b10000 || ram_strobes != r0 || blk_strobes != b0) begin
            failures++;
            $display("FAIL empty_ignore_trailing: got done=%b error=%b code=%0d strobes=%0d/%0d expected done=1 error=0 code=0 strobes=0/0",
                     done, error, err_code, ram_strobes - r0, blk_strobes - b0);
        end
    endtask

    task automatic test_bad_magic();
        int r0, b0;
        r0 = ram_strobes; b0 = blk_strobes;
        begin_dl();
        send_byte(8'h4E);
        checks++;
        if ({error, err_code, busy, done} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL bad_magic: got error=%b code=%0d busy=%b done=%b expected error=1 code=1 busy=0 done=0",
                     error, err_code, busy, done);
        end
        end_dl();
        begin_dl();
        idle_cycles(1);
        checks++;
        if ({error, err_code, busy} !== {1'b0, 3'd0, 1'b1}) begin
            failures++;
            $display("FAIL restart_clears: got error=%b code=%0d busy=%b expected error=0 code=0 busy=1",
                     error, err_code, busy);
        end
        send_byte(8'h4D); send_byte(8'h00); send_byte(8'h00);
        end_dl();
        checks++;
        if ({done, error} !== 2'b10 || ram_strobes != r0 || blk_strobes != b0) begin
            failures++;
            $display("FAIL restart_complete: got done=%b error=%b strobes=%0d/%0d expected done=1 error=0 strobes=0/0",
                     done, error, ram_strobes - r0, blk_strobes - b0);
        end
    endtask

    task automatic test_range_error();
        begin_dl();
        send_byte(8'h4D); send_byte(8'h11);
        checks++;
        if ({error, err_code} !== {1'b1, 3'd2}) begin
            failures++;
            $display("FAIL nram_range: got error=%b code=%0d expected error=1 code=2", error, err_code);
        end
        send_byte(8'h00);
        end_dl();
        checks++;
        if (err_code !== 3'd2) begin
            failures++;
            $display("FAIL first_error_latched: got code=%0d expected 2", err_code);
        end
    endtask

    task automatic test_field_error();
        int b0;
        b0 = blk_strobes;
        begin_dl();
        send_byte(8'h4D); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h13);
        checks++;
        if ({error, err_code} !== {1'b1, 3'd3}) begin
            failures++;
            $display("FAIL mapper_field: got error=%b code=%0d expected error=1 code=3", error, err_code);
        end
        send_byte(8'h00);
        end_dl();
        idle_cycles(1);
        checks++;
        if (blk_strobes != b0) begin
            failures++;
            $display("FAIL mapper_field_no_write: got %0d blk strobes expected 0", blk_strobes - b0);
        end
    endtask

    task automatic test_dangling_ref();
        int r0, b0;
        r0 = ram_strobes; b0 = blk_strobes;
        begin_dl();
        send_byte(8'h4D); send_byte(8'h01); send_byte(8'h01);
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h02);
        checks++;
        if ({error, err_code} !== {1'b1, 3'd4}) begin
            failures++;
            $display("FAIL dangling_ref: got error=%b code=%0d expected error=1 code=4", error, err_code);
        end
        end_dl();
        checks++;
        if ((ram_strobes - r0) != 1 || blk_strobes != b0) begin
            failures++;
            $display("FAIL dangling_strobes: got ram=%0d blk=%0d expected 1 0", ram_strobes - r0, blk_strobes - b0);
        end
    endtask

    task automatic test_truncation();
        int r0;
        r0 = ram_strobes;
        begin_dl();
        send_byte(8'h4D); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        checks++;
        if ({busy, error} !== 2'b10) begin
            failures++;
            $display("FAIL trunc_midrecord: got busy=%b error=%b expected busy=1 error=0", busy, error);
        end
        end_dl();
        checks++;
        if ({error, err_code, busy, done} !== {1'b1, 3'd5, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL truncation: got error=%b code=%0d busy=%b done=%b expected error=1 code=5 busy=0 done=0",
                     error, err_code, busy, done);
        end
        idle_cycles(2);
        checks++;
        if (ram_strobes != r0) begin
            failures++;
            $display("FAIL trunc_no_write: got %0d ram strobes expected 0", ram_strobes - r0);
        end
    endtask

    task automatic test_last_byte_on_fall();
        begin_dl();
        send_byte(8'h4D); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        dl_active = 1'b0;
        send_byte(8'h00);
        checks++;
        if ({done, error, blk_we, blk_idx} !== {1'b1, 1'b0, 1'b1, 6'd5}) begin
            failures++;
            $display("FAIL fall_with_last_byte: got done=%b error=%b blk_we=%b idx=%0d expected done=1 error=0 blk_we=1 idx=5",
                     done, error, blk_we, blk_idx);
        end
        idle_cycles(1);
    endtask

    task automatic test_back_to_back();
        begin_dl();
        send_byte(8'h4D); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'hC0); send_byte(8'h60); send_byte(8'h03);
        checks++;
        if ({blk_we, blk_idx, blk_offset_ram, blk_cart_num, blk_external, blk_device, done} !==
            {1'b1, 6'd1, 2'd3, 1'b1, 1'b1, 4'd3, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first: got we=%b idx=%0d off=%0d cart=%b ext=%b dev=%0d done=%b expected we=1 idx=1 off=3 cart=1 ext=1 dev=3 done=0",
                     blk_we, blk_idx, blk_offset_ram, blk_cart_num, blk_external, blk_device, done);
        end
        send_byte(8'h02); send_byte(8'h30); send_byte(8'h00);
        checks++;
        if (blk_we !== 1'b0) begin failures++; $display("FAIL b2b_gap: got blk_we=%b expected 0", blk_we); end
        send_byte(8'h04);
        checks++;
        if ({blk_we, blk_idx, blk_ref_sram, blk_offset_ram, blk_cart_num, blk_device, done} !==
            {1'b1, 6'd2, 2'd3, 2'd0, 1'b0, 4'd4, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second: got we=%b idx=%0d sram=%0d off=%0d cart=%b dev=%0d done=%b expected we=1 idx=2 sram=3 off=0 cart=0 dev=4 done=1",
                     blk_we, blk_idx, blk_ref_sram, blk_offset_ram, blk_cart_num, blk_device, done);
        end
        end_dl();
    endtask

    task automatic test_reset_mid_record();
        logic [80:0] all_out;
        int b0;
        begin_dl();
        send_byte(8'h4D); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h0A); send_byte(8'h00);
        b0 = blk_strobes;
        reset_n = 1'b0;
        dl_active = 1'b0;
        #1;
        all_out = {ram_we, ram_idx, ram_addr, ram_size, ram_ro, blk_we, blk_idx, blk_ref_ram,
                   blk_ref_sram, blk_offset_ram, blk_mapper, blk_device, blk_cart_num,
                   blk_external, busy, done, error, err_code};
        checks++;
        if (all_out !== 81'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h expected 0", all_out);
        end
        idle_cycles(2);
        reset_n = 1'b1;
        idle_cycles(1);
        begin_dl();
        send_byte(8'h4D); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h3F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        end_dl();
        checks++;
        if ({done, error, blk_idx, blk_device} !== {1'b1, 1'b0, 6'd63, 4'd2} || (blk_strobes - b0) != 1) begin
            failures++;
            $display("FAIL reset_then_clean: got done=%b error=%b idx=%0d dev=%0d strobes=%0d expected done=1 error=0 idx=63 dev=2 strobes=1",
                     done, error, blk_idx, blk_device, blk_strobes - b0);
        end
    endtask

    initial begin
        test_reset();
        test_valid_image();
        test_empty_header();
        test_bad_magic();
        test_range_error();
        test_field_error();
        test_dangling_ref();
        test_truncation();
        test_last_byte_on_fall();
        test_back_to_back();
        test_reset_mid_record();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
